// File: rtl/jbi_sc1_rtn_asm_if.sv
// ---------------------------------------------------------------------------
// jbi_sc1_rtn_asm_if
// Bundles the registered scbuf return stream (input side of the assembler)
// and the doubleword return channel towards the JBI (output side).
//
// Signals:
//   scbuf_jbi_data_d1      32  registered return data / ctag on the ctag beat
//   scbuf_jbi_ctag_vld_d1   1  marks the ctag beat
//   scbuf_jbi_ue_err_d1     1  uncorrectable error on the current data beat
//   rtn_vld                 1  FIFO head valid
//   rtn_rdy                 1  consumer ready
//   rtn_ctag               32  ctag of the head dword
//   rtn_data               64  head dword, earlier beat in [63:32]
//   rtn_idx                IW  dword index within the line
//   rtn_last                1  head is the final dword of its line
//   rtn_ue                  1  UE status of the head dword
//
// Handshake: a dword transfers on every rising rclk where rtn_vld & rtn_rdy.
// rtn_vld never depends on rtn_rdy, and while rtn_vld & !rtn_rdy the head
// fields hold steady. The scbuf stream has no ready: one beat per cycle.
//
// Modports: slave = the assembler, master = the environment around it
// (drives the scbuf stream and rtn_rdy, observes the return channel).
// ---------------------------------------------------------------------------
interface jbi_sc1_rtn_asm_if #(
  parameter int BEATS = 16
);
  localparam int IW = (BEATS / 2 > 1) ? $clog2(BEATS / 2) : 1;

  logic [31:0]   scbuf_jbi_data_d1;
  logic          scbuf_jbi_ctag_vld_d1;
  logic          scbuf_jbi_ue_err_d1;
  logic          rtn_vld;
  logic          rtn_rdy;
  logic [31:0]   rtn_ctag;
  logic [63:0]   rtn_data;
  logic [IW-1:0] rtn_idx;
  logic          rtn_last;
  logic          rtn_ue;

  modport slave (
    input  scbuf_jbi_data_d1, scbuf_jbi_ctag_vld_d1, scbuf_jbi_ue_err_d1,
    input  rtn_rdy,
    output rtn_vld, rtn_ctag, rtn_data, rtn_idx, rtn_last, rtn_ue
  );

  modport master (
    output scbuf_jbi_data_d1, scbuf_jbi_ctag_vld_d1, scbuf_jbi_ue_err_d1,
    output rtn_rdy,
    input  rtn_vld, rtn_ctag, rtn_data, rtn_idx, rtn_last, rtn_ue
  );
endinterface

// File: rtl/jbi_sc1_rtn_asm.sv
// ---------------------------------------------------------------------------
// jbi_sc1_rtn_asm
// Return-data assembler on the JBI side of sctag1. Takes one ctag beat and
// BEATS 32-bit data beats, packs beat pairs into 64-bit dwords tagged with
// ctag/idx/last/ue and queues them in a FIFO_DEPTH-entry FIFO.
//
// Ports:
//   rclk       clock
//   rst        asynchronous active-high reset
//   bus        jbi_sc1_rtn_asm_if.slave (scbuf stream in, return channel out)
//   ovf_err    sticky: a dword was dropped because the FIFO was full
//   proto_err  sticky: a ctag beat arrived mid-line
//   busy       FSM not idle or FIFO not empty
//   dbg_state  current FSM state (0 IDLE, 1 HI, 2 LO)
//
// Optional feature macro: JBI_SC1_RTN_UE_STICKY_EN -- once a UE is seen in
// a line, every later dword of that line also reports rtn_ue=1.
// ---------------------------------------------------------------------------
module jbi_sc1_rtn_asm #(
  parameter int BEATS      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                rclk,
  input  logic                rst,
  jbi_sc1_rtn_asm_if.slave    bus,
  output logic                ovf_err,
  output logic                proto_err,
  output logic                busy,
  output logic [1:0]          dbg_state
);
  localparam int IW = (BEATS / 2 > 1) ? $clog2(BEATS / 2) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(BEATS / 2 - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   ctag_q, ctag_d;
  logic [31:0]   hi_data_q, hi_data_d;
  logic          hi_ue_q, hi_ue_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ovf_q, proto_q, proto_set;
  logic          push, dw_ue, dw_last;
`ifdef JBI_SC1_RTN_UE_STICKY_EN
  logic          line_ue_q, line_ue_d;
`endif

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [31:0]   mem_ctag [FIFO_DEPTH];
  logic [63:0]   mem_data [FIFO_DEPTH];
  logic [IW-1:0] mem_idx  [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];
  logic          mem_ue   [FIFO_DEPTH];
  logic [PW:0]   wr_q, rd_q;
  logic          empty, full, pop, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop     = !empty && bus.rtn_rdy;
  // A simultaneous pop frees the slot, so a full FIFO still takes the push.
  assign push_ok = push && (!full || pop);
  assign dw_last = (idx_q == IDX_LAST);

  always_comb begin
    state_d   = state_q;
    ctag_d    = ctag_q;
    hi_data_d = hi_data_q;
    hi_ue_d   = hi_ue_q;
    idx_d     = idx_q;
    push      = 1'b0;
    proto_set = 1'b0;
`ifdef JBI_SC1_RTN_UE_STICKY_EN
    line_ue_d = line_ue_q;
    dw_ue     = hi_ue_q | bus.scbuf_jbi_ue_err_d1 | line_ue_q;
`else
    dw_ue     = hi_ue_q | bus.scbuf_jbi_ue_err_d1;
`endif
    if (bus.scbuf_jbi_ctag_vld_d1) begin
      // A ctag beat always starts a new line; mid-line it is a protocol error
      // and the partial dword is abandoned.
      proto_set = (state_q != IDLE);
      ctag_d    = bus.scbuf_jbi_data_d1;
      idx_d     = '0;
`ifdef JBI_SC1_RTN_UE_STICKY_EN
      line_ue_d = 1'b0;
`endif
      state_d   = HI;
    end else begin
      case (state_q)
        HI: begin
          hi_data_d = bus.scbuf_jbi_data_d1;
          hi_ue_d   = bus.scbuf_jbi_ue_err_d1;
          state_d   = LO;
        end
        LO: begin
          push = 1'b1;
`ifdef JBI_SC1_RTN_UE_STICKY_EN
          line_ue_d = dw_ue;
`endif
          if (dw_last) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = HI;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ctag_q    <= '0;
      hi_data_q <= '0;
      hi_ue_q   <= 1'b0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      proto_q   <= 1'b0;
`ifdef JBI_SC1_RTN_UE_STICKY_EN
      line_ue_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctag_q    <= ctag_d;
      hi_data_q <= hi_data_d;
      hi_ue_q   <= hi_ue_d;
      idx_q     <= idx_d;
      if (push && !push_ok) ovf_q <= 1'b1;
      if (proto_set) proto_q <= 1'b1;
`ifdef JBI_SC1_RTN_UE_STICKY_EN
      line_ue_q <= line_ue_d;
`endif
    end
  end

  // Storage is reset so that the head fields read as zero out of reset.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_ctag[i] <= '0;
        mem_data[i] <= '0;
        mem_idx[i]  <= '0;
        mem_last[i] <= 1'b0;
        mem_ue[i]   <= 1'b0;
      end
    end else begin
      if (push_ok) begin
        mem_ctag[wr_q[PW-1:0]] <= ctag_q;
        mem_data[wr_q[PW-1:0]] <= {hi_data_q, bus.scbuf_jbi_data_d1};
        mem_idx[wr_q[PW-1:0]]  <= idx_q;
        mem_last[wr_q[PW-1:0]] <= dw_last;
        mem_ue[wr_q[PW-1:0]]   <= dw_ue;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign bus.rtn_vld  = !empty;
  assign bus.rtn_ctag = mem_ctag[rd_q[PW-1:0]];
  assign bus.rtn_data = mem_data[rd_q[PW-1:0]];
  assign bus.rtn_idx  = mem_idx[rd_q[PW-1:0]];
  assign bus.rtn_last = mem_last[rd_q[PW-1:0]];
  assign bus.rtn_ue   = mem_ue[rd_q[PW-1:0]];
  assign ovf_err      = ovf_q;
  assign proto_err    = proto_q;
  assign busy         = (state_q != IDLE) || !empty;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_jbi_sc1_rtn_asm.sv
// ---------------------------------------------------------------------------
// tb_jbi_sc1_rtn_asm
// Drives directed and random scbuf return streams into jbi_sc1_rtn_asm and
// compares every cycle against a line-level model: beats of the current
// line are collected in an array, each completed pair becomes an expected
// dword, and a queue stands in for the return FIFO.
// ---------------------------------------------------------------------------
module tb_jbi_sc1_rtn_asm;
  localparam int BEATS = 16;
  localparam int DEPTH = 4;
  localparam int IW    = 3;
  localparam int W     = 32 + 64 + IW + 2;

  logic       rclk = 1'b0;
  logic       rst  = 1'b0;
  logic       ovf_err, proto_err, busy;
  logic [1:0] dbg_state;

  jbi_sc1_rtn_asm_if #(.BEATS(BEATS)) bus ();

  jbi_sc1_rtn_asm #(.BEATS(BEATS), .FIFO_DEPTH(DEPTH)) dut (
    .rclk      (rclk),
    .rst       (rst),
    .bus       (bus),
    .ovf_err   (ovf_err),
    .proto_err (proto_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 rclk = ~rclk;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];       // {ctag, data, idx, last, ue}
  bit           m_active;
  int           m_cnt;
  logic [31:0]  m_ctag;
  logic [31:0]  m_beat [BEATS];
  bit           m_bue  [BEATS];
  bit           m_lue, m_ovf, m_proto;
  int           tests = 0;
  int           fails = 0;

  task automatic model_reset();
    exp_q.delete();
    m_active = 0; m_cnt = 0; m_lue = 0; m_ovf = 0; m_proto = 0; m_ctag = '0;
  endtask

  task automatic model_step(input bit cv, input logic [31:0] d, input bit ue,
                            input bit rdy);
    bit           pop, acc, due, last;
    logic [W-1:0] e;
    acc = 0;
    e   = '0;
    pop = (exp_q.size() > 0) && rdy;
    if (cv) begin
      if (m_active) m_proto = 1;
      m_active = 1; m_cnt = 0; m_ctag = d; m_lue = 0;
    end else if (m_active) begin
      m_beat[m_cnt] = d;
      m_bue[m_cnt]  = ue;
      m_cnt++;
      if (m_cnt % 2 == 0) begin
        due = m_bue[m_cnt-2] | m_bue[m_cnt-1];
`ifdef JBI_SC1_RTN_UE_STICKY_EN
        due   = due | m_lue;
        m_lue = due;
`endif
        last = (m_cnt == BEATS);
        e = {m_ctag, m_beat[m_cnt-2], m_beat[m_cnt-1], IW'(m_cnt / 2 - 1), last, due};
        if (exp_q.size() < DEPTH || pop) acc = 1;
        else m_ovf = 1;
        if (last) m_active = 0;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(e);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] h;
    chk("rtn_vld", 64'(bus.rtn_vld), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("rtn_ctag", 64'(bus.rtn_ctag), 64'(h[W-1 -: 32]));
      chk("rtn_data", bus.rtn_data, h[IW+65 -: 64]);
      chk("rtn_idx",  64'(bus.rtn_idx),  64'(h[IW+1 -: IW]));
      chk("rtn_last", 64'(bus.rtn_last), 64'(h[1]));
      chk("rtn_ue",   64'(bus.rtn_ue),   64'(h[0]));
    end
    chk("ovf_err",   64'(ovf_err),   64'(m_ovf));
    chk("proto_err", 64'(proto_err), 64'(m_proto));
    chk("busy",      64'(busy),      64'(m_active || exp_q.size() > 0));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are checked
  // just before the next edge and the model advances with that edge.
  task automatic step(input bit cv, input logic [31:0] d, input bit ue, input bit rdy);
    bus.scbuf_jbi_ctag_vld_d1 = cv;
    bus.scbuf_jbi_data_d1     = d;
    bus.scbuf_jbi_ue_err_d1   = ue;
    bus.rtn_rdy               = rdy;
    #1;
    check_outputs();
    model_step(cv, d, ue, rdy);
    @(posedge rclk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, rdy);
  endtask

  // nb beats after the ctag; seq selects data = beat number instead of random
  task automatic send_line(input logic [31:0] ctag, input int nb, input bit rdy,
                           input int ue_beat, input bit seq);
    step(1'b1, ctag, 1'b0, rdy);
    for (int i = 0; i < nb; i++)
      step(1'b0, seq ? 32'(i) : 32'($urandom), (i == ue_beat), rdy);
  endtask

  task automatic do_reset();
    bus.scbuf_jbi_ctag_vld_d1 = 1'b0;
    bus.scbuf_jbi_data_d1     = '0;
    bus.scbuf_jbi_ue_err_d1   = 1'b0;
    bus.rtn_rdy               = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_vld",   64'(bus.rtn_vld),  64'(0));
    chk("rst_ctag",  64'(bus.rtn_ctag), 64'(0));
    chk("rst_data",  bus.rtn_data,      64'(0));
    chk("rst_idx",   64'(bus.rtn_idx),  64'(0));
    chk("rst_last",  64'(bus.rtn_last), 64'(0));
    chk("rst_ue",    64'(bus.rtn_ue),   64'(0));
    chk("rst_flags", 64'({ovf_err, proto_err, busy}), 64'(0));
    @(posedge rclk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();
    idle(2, 1'b1);

    // basic line, always ready
    send_line(32'hA5A5_0001, BEATS, 1'b1, -1, 1'b1);
    idle(4, 1'b1);

    // same line with back-pressure: 4 held, 4 dropped, then drain
    send_line(32'hA5A5_0001, BEATS, 1'b0, -1, 1'b1);
    idle(2, 1'b0);
    chk("ovf_set", 64'(ovf_err), 64'(1));
    idle(6, 1'b1);
    chk("busy_drained", 64'(busy), 64'(0));

    // UE on beat 5
    do_reset();
    send_line(32'h0000_BEEF, BEATS, 1'b1, 5, 1'b0);
    idle(4, 1'b1);

    // ctag mid-line
    send_line(32'h1, 5, 1'b1, -1, 1'b0);
    send_line(32'h2, BEATS, 1'b1, -1, 1'b0);
    idle(4, 1'b1);
    chk("proto_set", 64'(proto_err), 64'(1));

    // back-to-back lines, no errors after a fresh reset
    do_reset();
    send_line(32'hCAFE_0001, BEATS, 1'b1, -1, 1'b0);
    send_line(32'hCAFE_0002, BEATS, 1'b1, 3, 1'b0);
    idle(4, 1'b1);
    chk("b2b_no_err", 64'({ovf_err, proto_err}), 64'(0));

    // reset after beat 7, stray beats, then a full line
    send_line(32'hD00D_0001, 8, 1'b1, -1, 1'b0);
    do_reset();
    idle(5, 1'b1);
    send_line(32'hD00D_0002, BEATS, 1'b1, -1, 1'b0);
    idle(4, 1'b1);

    // random traffic: mostly well-formed lines with random ready and UE
    do_reset();
    for (int l = 0; l < 25; l++) begin
      send_line($urandom, ($urandom_range(0, 9) == 0) ? $urandom_range(1, BEATS-1) : BEATS,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? $urandom_range(0, BEATS-1) : -1,
                1'b0);
      for (int i = 0; i < $urandom_range(0, 3); i++)
        step(1'b0, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
    end
    idle(8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
